sine_sweep_ctrl: RTL and testbench

- Synthesizable frequency-sweep scheduler for the sine stimulus path.
- Owns a phase accumulator that drives the sine lookup and steps the frequency control word (FCW) through a programmed sweep.
- Each step has a settle window, then a capture window; capture_valid strobes the downstream CIC capture/measurement logic.
- Sample timing comes from an external sample_en tick, so one controller serves any sampling rate.

---
 rtl/sine_sweep_ctrl_if.sv | 39 +++
 rtl/sine_sweep_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sine_sweep_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_sweep_ctrl_if.sv
// Sweep controller bus: configuration, control strobes and tone/status outputs.
interface sine_sweep_ctrl_if #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned CNT_W   = 16
);
  logic               start;
  logic               abort;
  logic               sample_en;
  logic [PHASE_W-1:0] fcw_start;
  logic [PHASE_W-1:0] fcw_step;
  logic [STEP_W-1:0]  num_steps;
  logic [CNT_W-1:0]   settle_cycles;
  logic [CNT_W-1:0]   capture_cycles;
  logic [PHASE_W-1:0] phase_out;
  logic [PHASE_W-1:0] fcw_out;
  logic               tone_en;
  logic               capture_valid;
  logic [STEP_W-1:0]  step_idx;
  logic               step_done;
  logic               busy;
  logic               done;

  // Stimulus side: drives control/configuration, observes status.
  modport master (
    output start, abort, sample_en, fcw_start, fcw_step, num_steps,
           settle_cycles, capture_cycles,
    input  phase_out, fcw_out, tone_en, capture_valid, step_idx,
           step_done, busy, done
  );

  // Controller side.
  modport slave (
    input  start, abort, sample_en, fcw_start, fcw_step, num_steps,
           settle_cycles, capture_cycles,
    output phase_out, fcw_out, tone_en, capture_valid, step_idx,
           step_done, busy, done
  );
endinterface

// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep scheduler: phase accumulator plus settle/capture step sequencing.
// Optional build macro SWEEP_PHASE_RESET_EN: restart phase at 0 on every new step.
module sine_sweep_ctrl #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  sine_sweep_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_NEXT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state, w_state;
  logic [PHASE_W-1:0] r_phase, w_phase;
  logic [PHASE_W-1:0] r_fcw, w_fcw;
  logic [PHASE_W-1:0] r_fcw_step, w_fcw_step;
  logic [STEP_W-1:0]  r_last_step, w_last_step;
  logic [CNT_W-1:0]   r_settle, w_settle;
  logic [CNT_W-1:0]   r_capture, w_capture;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [STEP_W-1:0]  r_step_idx, w_step_idx;
  logic               r_tone, w_tone;
  logic               r_cap_valid, w_cap_valid;
  logic               r_step_done, w_step_done;
  logic               r_busy, w_busy;
  logic               r_done, w_done;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [PHASE_W-1:0] w_phase_inc;

  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_phase_inc = r_phase + r_fcw;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state;
  end

  // Next-state and next-register values; abort overrides everything outside IDLE.
  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_fcw       = r_fcw;
    w_fcw_step  = r_fcw_step;
    w_last_step = r_last_step;
    w_settle    = r_settle;
    w_capture   = r_capture;
    w_cnt       = r_cnt;
    w_step_idx  = r_step_idx;
    w_tone      = r_tone;
    w_cap_valid = 1'b0;
    w_step_done = 1'b0;
    w_busy      = r_busy;
    w_done      = r_done;

    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_fcw_step  = bus.fcw_step;
          w_last_step = (bus.num_steps == '0) ? '0 : bus.num_steps - STEP_W'(1);
          w_settle    = bus.settle_cycles;
          w_capture   = (bus.capture_cycles == '0) ? CNT_W'(1) : bus.capture_cycles;
          w_fcw       = bus.fcw_start;
          w_step_idx  = '0;
          w_phase     = '0;
          w_cnt       = '0;
          w_done      = 1'b0;
          w_busy      = 1'b1;
          w_tone      = 1'b1;
          w_state     = (bus.settle_cycles == '0) ? S_CAPTURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.sample_en) begin
          w_phase = w_phase_inc;
          if (w_cnt_inc == r_settle) begin
            w_cnt   = '0;
            w_state = S_CAPTURE;
          end else begin
            w_cnt   = w_cnt_inc;
          end
        end
      end
      S_CAPTURE: begin
        if (bus.sample_en) begin
          w_phase     = w_phase_inc;
          w_cap_valid = 1'b1;
          if (w_cnt_inc == r_capture) begin
            w_cnt       = '0;
            w_tone      = 1'b0;
            w_step_done = 1'b1;
            w_state     = S_NEXT;
          end else begin
            w_cnt       = w_cnt_inc;
          end
        end
      end
      S_NEXT: begin
        if (r_step_idx == r_last_step) begin
          w_state    = S_DONE;
        end else begin
          w_step_idx = r_step_idx + STEP_W'(1);
          w_fcw      = r_fcw + r_fcw_step;
          w_tone     = 1'b1;
`ifdef SWEEP_PHASE_RESET_EN
          w_phase    = '0;
`else
          w_phase    = r_phase;
`endif
          w_state    = (r_settle == '0) ? S_CAPTURE : S_SETTLE;
        end
      end
      S_DONE: begin
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    if (bus.abort && (r_state != S_IDLE)) begin
      w_state     = S_IDLE;
      w_phase     = r_phase;
      w_fcw       = r_fcw;
      w_step_idx  = r_step_idx;
      w_cnt       = '0;
      w_tone      = 1'b0;
      w_cap_valid = 1'b0;
      w_step_done = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase     <= '0;
      r_fcw       <= '0;
      r_fcw_step  <= '0;
      r_last_step <= '0;
      r_settle    <= '0;
      r_capture   <= '0;
      r_cnt       <= '0;
      r_step_idx  <= '0;
      r_tone      <= 1'b0;
      r_cap_valid <= 1'b0;
      r_step_done <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_phase     <= w_phase;
      r_fcw       <= w_fcw;
      r_fcw_step  <= w_fcw_step;
      r_last_step <= w_last_step;
      r_settle    <= w_settle;
      r_capture   <= w_capture;
      r_cnt       <= w_cnt;
      r_step_idx  <= w_step_idx;
      r_tone      <= w_tone;
      r_cap_valid <= w_cap_valid;
      r_step_done <= w_step_done;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign bus.phase_out     = r_phase;
  assign bus.fcw_out       = r_fcw;
  assign bus.tone_en       = r_tone;
  assign bus.capture_valid = r_cap_valid;
  assign bus.step_idx      = r_step_idx;
  assign bus.step_done     = r_step_done;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Self-checking bench for sine_sweep_ctrl against a step-by-step arithmetic sweep model.
// Build with SWEEP_PHASE_RESET_EN defined to check the per-step phase restart variant.
module tb_sine_sweep_ctrl;
  localparam int unsigned PHASE_W = 24;
  localparam int unsigned STEP_W  = 8;
  localparam int unsigned CNT_W   = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sine_sweep_ctrl_if #(.PHASE_W(PHASE_W), .STEP_W(STEP_W), .CNT_W(CNT_W)) bus ();

  sine_sweep_ctrl #(.PHASE_W(PHASE_W), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PHASE_W-1:0] cfg_fcw_start, cfg_fcw_step;
  logic [STEP_W-1:0]  cfg_num;
  logic [CNT_W-1:0]   cfg_settle, cfg_capture;

  logic [PHASE_W-1:0] exp_phase[$], exp_fcw[$], exp_start[$];
  int                 exp_idx[$];
  int                 exp_steps;

  logic [PHASE_W-1:0] obs_phase[$], obs_fcw[$], obs_start[$];
  int                 obs_idx[$];
  int                 obs_step_done, obs_first_tick;
  logic               obs_busy0, obs_tone0;

  // Reference: walk every step, accumulating phase once per counted tick.
  task automatic build_model();
    int steps = (cfg_num == 0) ? 1 : int'(cfg_num);
    int caps  = (cfg_capture == 0) ? 1 : int'(cfg_capture);
    logic [PHASE_W-1:0] ph = '0;
    logic [PHASE_W-1:0] f;
    exp_phase.delete(); exp_fcw.delete(); exp_start.delete(); exp_idx.delete();
    for (int s = 0; s < steps; s++) begin
      f = cfg_fcw_start + PHASE_W'(s) * cfg_fcw_step;
      if (s > 0) begin
`ifdef SWEEP_PHASE_RESET_EN
        ph = '0;
`endif
        exp_start.push_back(ph);
      end
      for (int t = 0; t < int'(cfg_settle); t++) ph = ph + f;
      for (int t = 0; t < caps; t++) begin
        ph = ph + f;
        exp_phase.push_back(ph); exp_fcw.push_back(f); exp_idx.push_back(s);
      end
    end
    exp_steps = steps;
  endtask

  // Index of the first disagreement between observed and modelled sweep, -1 if none.
  function automatic int first_bad();
    if (obs_phase.size() != exp_phase.size()) return 1000000 + obs_phase.size();
    if (obs_start.size() != exp_start.size()) return 2000000 + obs_start.size();
    for (int i = 0; i < exp_phase.size(); i++)
      if (obs_phase[i] !== exp_phase[i] || obs_fcw[i] !== exp_fcw[i] || obs_idx[i] != exp_idx[i])
        return i;
    for (int i = 0; i < exp_start.size(); i++)
      if (obs_start[i] !== exp_start[i]) return 3000000 + i;
    return -1;
  endfunction

  task automatic drive_cfg();
    bus.fcw_start      = cfg_fcw_start;
    bus.fcw_step       = cfg_fcw_step;
    bus.num_steps      = cfg_num;
    bus.settle_cycles  = cfg_settle;
    bus.capture_cycles = cfg_capture;
  endtask

  // Start one sweep and record every capture, step_done and step-start phase until done.
  task automatic run_sweep(input bit rand_ticks, input bit perturb, output bit timed_out);
    int cyc = 0;
    int ticks = 0;
    int prev_idx;
    bit se;
    obs_phase.delete(); obs_fcw.delete(); obs_start.delete(); obs_idx.delete();
    obs_step_done = 0; obs_first_tick = -1;
    drive_cfg();
    bus.sample_en = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    obs_busy0 = bus.busy; obs_tone0 = bus.tone_en;
    prev_idx = int'(bus.step_idx);
    timed_out = 1'b1;
    while (cyc < 4000) begin
      se = rand_ticks ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 3);
      bus.sample_en = se;
      if (se) ticks++;
      if (perturb && cyc == 20) begin
        bus.start = 1'b1;
        bus.fcw_start = PHASE_W'($urandom); bus.fcw_step = PHASE_W'($urandom);
        bus.num_steps = STEP_W'($urandom);  bus.settle_cycles = CNT_W'($urandom);
        bus.capture_cycles = CNT_W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (bus.capture_valid) begin
        obs_phase.push_back(bus.phase_out); obs_fcw.push_back(bus.fcw_out);
        obs_idx.push_back(int'(bus.step_idx));
        if (obs_first_tick < 0) obs_first_tick = ticks;
      end
      if (bus.step_done) obs_step_done++;
      if (int'(bus.step_idx) != prev_idx) begin
        obs_start.push_back(bus.phase_out);
        prev_idx = int'(bus.step_idx);
      end
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.sample_en = 1'b0;
    bus.start = 1'b0;
    drive_cfg();
  endtask

  task automatic set_basic();
    cfg_fcw_start = 24'h000100; cfg_fcw_step = 24'h000100;
    cfg_num = 8'd3; cfg_settle = 16'd2; cfg_capture = 16'd4;
  endtask

  task automatic test_reset();
    logic [3*PHASE_W-1:0] v;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    v = {bus.phase_out, bus.fcw_out, bus.tone_en, bus.capture_valid, bus.step_idx,
         bus.step_done, bus.busy, bus.done};
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", v); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tone_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy=%b tone=%b want 0", bus.busy, bus.tone_en);
    end
  endtask

  task automatic test_basic();
    bit to;
    int bad;
    logic [PHASE_W-1:0] want_s1;
    set_basic(); build_model();
    run_sweep(1'b0, 1'b0, to);
`ifdef SWEEP_PHASE_RESET_EN
    want_s1 = 24'h000000;
`else
    want_s1 = 24'h000600;
`endif
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: done never rose"); end
    n_checks++;
    if (obs_busy0 !== 1'b1 || obs_tone0 !== 1'b1) begin
      n_fail++; $display("FAIL basic_start: busy=%b tone=%b want 1 1", obs_busy0, obs_tone0);
    end
    n_checks++;
    if (obs_step_done != 3) begin n_fail++; $display("FAIL basic_step_done: got %0d want 3", obs_step_done); end
    n_checks++;
    if (obs_phase.size() != 12) begin n_fail++; $display("FAIL basic_captures: got %0d want 12", obs_phase.size()); end
    n_checks++;
    if (obs_phase.size() == 12 &&
        (obs_fcw[0] !== 24'h100 || obs_fcw[4] !== 24'h200 || obs_fcw[8] !== 24'h300)) begin
      n_fail++; $display("FAIL basic_fcw_seq: got %h %h %h want 100 200 300", obs_fcw[0], obs_fcw[4], obs_fcw[8]);
    end
    n_checks++;
    if (obs_start.size() < 1 || obs_start[0] !== want_s1) begin
      n_fail++; $display("FAIL basic_step1_phase: got %h want %h", (obs_start.size() > 0) ? obs_start[0] : 24'hx, want_s1);
    end
    bad = first_bad();
    n_checks++;
    if (bad != -1) begin n_fail++; $display("FAIL basic_model: first disagreement at %0d want none", bad); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_hold: done=%b busy=%b want 1 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_phase_wrap();
    bit to;
    cfg_fcw_start = 24'hFFFF00; cfg_fcw_step = 24'h000123;
    cfg_num = 8'd1; cfg_settle = 16'd0; cfg_capture = 16'd3;
    run_sweep(1'b1, 1'b0, to);
    n_checks++;
    if (to || obs_phase.size() != 3) begin
      n_fail++; $display("FAIL wrap_count: got %0d captures (timeout=%b) want 3", obs_phase.size(), to);
    end else if (obs_phase[0] !== 24'hFFFF00 || obs_phase[1] !== 24'hFFFE00 || obs_phase[2] !== 24'hFFFD00) begin
      n_fail++; $display("FAIL wrap_phase: got %h %h %h want FFFF00 FFFE00 FFFD00", obs_phase[0], obs_phase[1], obs_phase[2]);
    end
    n_checks++;
    if (obs_first_tick != 1) begin n_fail++; $display("FAIL wrap_first_tick: got %0d want 1", obs_first_tick); end
  endtask

  task automatic test_zero_fields();
    bit to;
    cfg_fcw_start = 24'h012345; cfg_fcw_step = 24'h000010;
    cfg_num = 8'd0; cfg_settle = 16'd0; cfg_capture = 16'd0;
    run_sweep(1'b1, 1'b0, to);
    n_checks++;
    if (to || obs_step_done != 1 || obs_phase.size() != 1) begin
      n_fail++; $display("FAIL zero_fields: steps=%0d caps=%0d timeout=%b want 1 1 0", obs_step_done, obs_phase.size(), to);
    end
    n_checks++;
    if (obs_phase.size() == 1 && obs_phase[0] !== 24'h012345) begin
      n_fail++; $display("FAIL zero_phase: got %h want 012345", obs_phase[0]);
    end
  endtask

  task automatic test_abort();
    int cyc = 0;
    int caps1 = 0;
    int sd = 0;
    bit to;
    logic [PHASE_W-1:0] want_ph;
`ifdef SWEEP_PHASE_RESET_EN
    want_ph = 24'h000800;
`else
    want_ph = 24'h000E00;
`endif
    set_basic(); drive_cfg();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < 2000 && caps1 < 2) begin
      bus.sample_en = (cyc % 4 == 3);
      @(negedge clk);
      cyc++;
      if (bus.capture_valid && bus.step_idx == 8'd1) caps1++;
    end
    bus.sample_en = 1'b0;
    n_checks++;
    if (caps1 < 2) begin n_fail++; $display("FAIL abort_reach: got %0d step-1 captures want 2", caps1); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tone_en !== 1'b0 || bus.done !== 1'b0 || bus.step_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_status: busy=%b tone=%b done=%b sd=%b want 0 0 0 0", bus.busy, bus.tone_en, bus.done, bus.step_done);
    end
    n_checks++;
    if (bus.phase_out !== want_ph || bus.fcw_out !== 24'h000200) begin
      n_fail++; $display("FAIL abort_hold: phase=%h fcw=%h want %h 000200", bus.phase_out, bus.fcw_out, want_ph);
    end
    for (int i = 0; i < 12; i++) begin
      bus.sample_en = (i % 3 == 0);
      @(negedge clk);
      if (bus.step_done || bus.busy) sd++;
    end
    bus.sample_en = 1'b0;
    n_checks++;
    if (sd != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", sd); end
    build_model();
    run_sweep(1'b1, 1'b0, to);
    n_checks++;
    if (to || obs_step_done != 3 || first_bad() != -1) begin
      n_fail++; $display("FAIL abort_restart: steps=%0d bad=%0d timeout=%b want 3 -1 0", obs_step_done, first_bad(), to);
    end
  endtask

  task automatic test_ignored_inputs();
    bit to;
    set_basic(); build_model();
    run_sweep(1'b0, 1'b1, to);
    n_checks++;
    if (to || obs_step_done != 3 || first_bad() != -1) begin
      n_fail++; $display("FAIL ignored_midsweep: steps=%0d bad=%0d timeout=%b want 3 -1 0", obs_step_done, first_bad(), to);
    end
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tone_en !== 1'b0 || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL start_abort_idle: busy=%b tone=%b done=%b want 0 0 1", bus.busy, bus.tone_en, bus.done);
    end
  endtask

  task automatic test_random();
    bit to;
    for (int k = 0; k < 6; k++) begin
      cfg_fcw_start = PHASE_W'($urandom); cfg_fcw_step = PHASE_W'($urandom);
      cfg_num = STEP_W'($urandom_range(0, 4)); cfg_settle = CNT_W'($urandom_range(0, 3));
      cfg_capture = CNT_W'($urandom_range(0, 4));
      build_model();
      run_sweep(1'b1, 1'b0, to);
      n_checks++;
      if (to || obs_step_done != exp_steps || first_bad() != -1 ||
          obs_first_tick != int'(cfg_settle) + 1) begin
        n_fail++;
        $display("FAIL random_%0d: steps=%0d/%0d bad=%0d first_tick=%0d/%0d timeout=%b",
                 k, obs_step_done, exp_steps, first_bad(), obs_first_tick, int'(cfg_settle) + 1, to);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3*PHASE_W-1:0] v;
    set_basic(); drive_cfg();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.sample_en = (i % 2 == 0);
      @(negedge clk);
    end
    bus.sample_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    v = {bus.phase_out, bus.fcw_out, bus.tone_en, bus.capture_valid, bus.step_idx,
         bus.step_done, bus.busy, bus.done};
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_mid: got %h want 0", v); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.sample_en = 1'b0;
    set_basic(); drive_cfg();
    test_reset();
    test_basic();
    test_phase_wrap();
    test_zero_fields();
    test_abort();
    test_ignored_inputs();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
